// File: rtl/hn_req_arbiter.sv
// hn_req_arbiter
// Round-robin arbiter that grants the single Home Node coherence controller
// to one of NUM_RN request nodes at a time. The winning request is captured
// into registers, then offered to the HN. The grant is held (LOCKED) until the
// HN reports completion. A watchdog forces release if completion never arrives.
module hn_req_arbiter #(
    parameter int NUM_RN      = 4,
    parameter int OPCODE_W    = 7,
    parameter int ADDR_W      = 44,
    parameter int TXNID_W     = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                          clk,
    input  logic                          rstn,

    // Request channels from the per-RN RX_REQ decoders
    input  logic [NUM_RN-1:0]             rn_req_valid,
    output logic [NUM_RN-1:0]             rn_req_ready,
    input  logic [NUM_RN*OPCODE_W-1:0]    rn_req_opcode,
    input  logic [NUM_RN*ADDR_W-1:0]      rn_req_addr,
    input  logic [NUM_RN*TXNID_W-1:0]     rn_req_txnid,

    // Request towards the HN controller
    output logic                          hn_req_valid,
    input  logic                          hn_req_ready,
    output logic [OPCODE_W-1:0]           hn_req_opcode,
    output logic [ADDR_W-1:0]             hn_req_addr,
    output logic [TXNID_W-1:0]            hn_req_txnid,
    output logic [6:0]                    hn_req_srcid,
    output logic [$clog2(NUM_RN)-1:0]     hn_grant_idx,
    input  logic                          hn_done,

    // Status
    output logic                          busy,
    output logic                          err_timeout
);

    localparam int IDX_W = $clog2(NUM_RN);

    // Last counter value in LOCKED before the watchdog forces release.
    localparam logic [15:0] WDOG_LAST = (TIMEOUT_CYC == 0) ? 16'd0 : 16'(TIMEOUT_CYC - 1);
    localparam logic [NUM_RN-1:0] ONE_RN = NUM_RN'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_OFFER  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [IDX_W-1:0]      r_rr_ptr;
    logic [15:0]           r_wdog_cnt;
    logic                  r_err_timeout;

    logic [OPCODE_W-1:0]   r_opcode;
    logic [ADDR_W-1:0]     r_addr;
    logic [TXNID_W-1:0]    r_txnid;
    logic [6:0]            r_srcid;
    logic [IDX_W-1:0]      r_grant_idx;

    logic                  w_found;
    logic [IDX_W-1:0]      w_winner;
    logic [IDX_W-1:0]      w_cand;
    logic                  w_accept;
    logic                  w_handshake;
    logic                  w_wdog_expire;
    logic                  w_timeout_set;

    // Round-robin search: first valid requester at or after r_rr_ptr, wrapping.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write so
        // no path leaves it unassigned; otherwise a latch would be inferred.
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = 0; k < NUM_RN; k++) begin
            // NUM_RN is a power of two, so truncation is the modulo wrap.
            w_cand = r_rr_ptr + IDX_W'(k);
            if (!w_found && rn_req_valid[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    // Transfer qualifiers derived from the current state.
    assign w_accept      = (r_state == S_IDLE) && w_found;
    assign w_handshake   = (r_state == S_OFFER) && hn_req_ready;
    assign w_wdog_expire = (TIMEOUT_CYC != 0) && (r_state == S_LOCKED)
                           && (r_wdog_cnt == WDOG_LAST);
    // Completion in the expiry cycle takes priority over the timeout.
    assign w_timeout_set = w_wdog_expire && !hn_done;

    // Next-state logic: accept in IDLE, HN handshake in OFFER, done/expiry in LOCKED.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_OFFER;
                end
            end
            S_OFFER: begin
                if (hn_req_ready) begin
                    w_state_nxt = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (hn_done || w_wdog_expire) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the winner's payload and advance the round-robin pointer on accept.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rr_ptr    <= '0;
            r_opcode    <= '0;
            r_addr      <= '0;
            r_txnid     <= '0;
            r_srcid     <= '0;
            r_grant_idx <= '0;
        end else if (w_accept) begin
            r_rr_ptr    <= w_winner + IDX_W'(1);
            r_opcode    <= rn_req_opcode[w_winner*OPCODE_W +: OPCODE_W];
            r_addr      <= rn_req_addr[w_winner*ADDR_W +: ADDR_W];
            r_txnid     <= rn_req_txnid[w_winner*TXNID_W +: TXNID_W];
            r_srcid     <= 7'd1 << w_winner;
            r_grant_idx <= w_winner;
        end
    end

    // Watchdog counter: cleared on the HN handshake, counts only while LOCKED.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wdog_cnt <= '0;
        end else if (w_handshake) begin
            r_wdog_cnt <= '0;
        end else if (r_state == S_LOCKED) begin
            r_wdog_cnt <= r_wdog_cnt + 16'd1;
        end
    end

    // Sticky timeout flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_err_timeout <= 1'b0;
        end else if (w_timeout_set) begin
            r_err_timeout <= 1'b1;
        end
    end

    // Accept is combinational in IDLE and suppressed while reset is asserted.
    assign rn_req_ready  = (rstn && w_accept) ? (ONE_RN << w_winner) : '0;

    assign hn_req_valid  = (r_state == S_OFFER);
    assign hn_req_opcode = r_opcode;
    assign hn_req_addr   = r_addr;
    assign hn_req_txnid  = r_txnid;
    assign hn_req_srcid  = r_srcid;
    assign hn_grant_idx  = r_grant_idx;
    assign busy          = (r_state != S_IDLE);
    assign err_timeout   = r_err_timeout;

endmodule

// File: tb/tb_hn_req_arbiter.sv
// Self-checking bench for hn_req_arbiter. A transaction-level model tracks the
// round-robin pointer, the per-RN payloads and the sticky timeout flag; each
// test task drives stimulus and compares DUT outputs against that model.
module tb_hn_req_arbiter;

    localparam int NUM_RN   = 4;
    localparam int OPCODE_W = 7;
    localparam int ADDR_W   = 44;
    localparam int TXNID_W  = 8;
    localparam int TMO      = 8;

    logic                       clk;
    logic                       rstn;
    logic [NUM_RN-1:0]          rn_req_valid;
    logic [NUM_RN-1:0]          rn_req_ready;
    logic [NUM_RN*OPCODE_W-1:0] rn_req_opcode;
    logic [NUM_RN*ADDR_W-1:0]   rn_req_addr;
    logic [NUM_RN*TXNID_W-1:0]  rn_req_txnid;
    logic                       hn_req_valid;
    logic                       hn_req_ready;
    logic [OPCODE_W-1:0]        hn_req_opcode;
    logic [ADDR_W-1:0]          hn_req_addr;
    logic [TXNID_W-1:0]         hn_req_txnid;
    logic [6:0]                 hn_req_srcid;
    logic [1:0]                 hn_grant_idx;
    logic                       hn_done;
    logic                       busy;
    logic                       err_timeout;

    hn_req_arbiter #(
        .NUM_RN     (NUM_RN),
        .OPCODE_W   (OPCODE_W),
        .ADDR_W     (ADDR_W),
        .TXNID_W    (TXNID_W),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .rn_req_valid (rn_req_valid),
        .rn_req_ready (rn_req_ready),
        .rn_req_opcode(rn_req_opcode),
        .rn_req_addr  (rn_req_addr),
        .rn_req_txnid (rn_req_txnid),
        .hn_req_valid (hn_req_valid),
        .hn_req_ready (hn_req_ready),
        .hn_req_opcode(hn_req_opcode),
        .hn_req_addr  (hn_req_addr),
        .hn_req_txnid (hn_req_txnid),
        .hn_req_srcid (hn_req_srcid),
        .hn_grant_idx (hn_grant_idx),
        .hn_done      (hn_done),
        .busy         (busy),
        .err_timeout  (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Everything the HN side sees for an offered request, in one vector.
    logic [68:0] obs_offer;
    assign obs_offer = {hn_req_valid, hn_req_opcode, hn_req_addr, hn_req_txnid,
                        hn_req_srcid, hn_grant_idx};

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int                  m_ptr;
    bit                  m_err;
    logic [OPCODE_W-1:0] m_op   [NUM_RN];
    logic [ADDR_W-1:0]   m_addr [NUM_RN];
    logic [TXNID_W-1:0]  m_txn  [NUM_RN];

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    // First requester in the mask at or after ptr, counting upward with wrap.
    function automatic int model_winner(input logic [NUM_RN-1:0] mask, input int ptr);
        for (int k = 0; k < NUM_RN; k++) begin
            if (mask[(ptr + k) % NUM_RN]) return (ptr + k) % NUM_RN;
        end
        return -1;
    endfunction

    // Expected HN-side view once RN w has been granted.
    function automatic logic [68:0] exp_offer(input int w);
        return {1'b1, m_op[w], m_addr[w], m_txn[w], 7'(1 << w), 2'(w)};
    endfunction

    task automatic load_payload();
        for (int i = 0; i < NUM_RN; i++) begin
            m_op[i]   = OPCODE_W'($urandom);
            m_addr[i] = ADDR_W'({$urandom, $urandom});
            m_txn[i]  = TXNID_W'($urandom);
            rn_req_opcode[i*OPCODE_W +: OPCODE_W] = m_op[i];
            rn_req_addr[i*ADDR_W +: ADDR_W]       = m_addr[i];
            rn_req_txnid[i*TXNID_W +: TXNID_W]    = m_txn[i];
        end
    endtask

    // Two reset cycles with all requesters active; ends at a drive point.
    task automatic do_reset();
        rstn = 1'b0;
        rn_req_valid = '1;
        hn_req_ready = 1'b1;
        hn_done = 1'b1;
        load_payload();
        to_neg();
        n_checks++;
        if (rn_req_ready !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_ready: got %b expected 0000", rn_req_ready);
        end
        to_drive();
        to_neg();
        n_checks++;
        if ({obs_offer, busy, err_timeout, rn_req_ready} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got offer=%h busy=%b err=%b ready=%b expected all zero",
                     obs_offer, busy, err_timeout, rn_req_ready);
        end
        to_drive();
        rstn = 1'b1;
        rn_req_valid = '0;
        hn_req_ready = 1'b0;
        hn_done = 1'b0;
        m_ptr = 0;
        m_err = 1'b0;
    endtask

    // One full transaction from an IDLE start. done_dly is the cycle after the
    // handshake carrying hn_done (1..TMO); without do_done the watchdog fires.
    // noise drives stray hn_done pulses in OFFER and IDLE, which must be ignored.
    task automatic do_txn(input logic [NUM_RN-1:0] mask, input int offer_wait,
                          input int done_dly, input bit do_done, input bit noise);
        int w;
        logic [68:0] exp;
        load_payload();
        rn_req_valid = mask;
        hn_req_ready = 1'b0;
        hn_done = noise ? 1'($urandom) : 1'b0;
        w = model_winner(mask, m_ptr);
        to_neg();
        n_checks++;
        if (rn_req_ready !== 4'(1 << w)) begin
            n_errors++;
            $display("FAIL accept_ready: got %b expected %b", rn_req_ready, 4'(1 << w));
        end
        m_ptr = (w + 1) % NUM_RN;
        exp = exp_offer(w);
        to_drive();
        // OFFER: requesters keep asserting valid; nothing must be accepted.
        for (int c = 0; c <= offer_wait; c++) begin
            hn_req_ready = (c == offer_wait);
            hn_done = (noise && c < offer_wait) ? 1'($urandom) : 1'b0;
            to_neg();
            n_checks++;
            if ({obs_offer, rn_req_ready, busy, err_timeout} !== {exp, 4'b0000, 1'b1, m_err}) begin
                n_errors++;
                $display("FAIL offer_cycle%0d: got offer=%h ready=%b busy=%b err=%b expected offer=%h ready=0000 busy=1 err=%b",
                         c, obs_offer, rn_req_ready, busy, err_timeout, exp, m_err);
            end
            to_drive();
        end
        hn_req_ready = 1'b0;
        // LOCKED: valid low, busy high, requesters stalled.
        for (int j = 1; j <= TMO; j++) begin
            hn_done = do_done && (j == done_dly);
            to_neg();
            n_checks++;
            if ({hn_req_valid, busy, rn_req_ready} !== {1'b0, 1'b1, 4'b0000}) begin
                n_errors++;
                $display("FAIL locked_cycle%0d: got valid=%b busy=%b ready=%b expected valid=0 busy=1 ready=0000",
                         j, hn_req_valid, busy, rn_req_ready);
            end
            to_drive();
            if (hn_done) begin
                hn_done = 1'b0;
                break;
            end
        end
        hn_done = 1'b0;
        if (!do_done) m_err = 1'b1;
        // Back in IDLE with no requester; a stray done here is ignored.
        rn_req_valid = '0;
        hn_done = noise ? 1'($urandom) : 1'b0;
        to_neg();
        n_checks++;
        if ({busy, err_timeout, hn_req_valid, rn_req_ready} !== {1'b0, m_err, 1'b0, 4'b0000}) begin
            n_errors++;
            $display("FAIL release: got busy=%b err=%b valid=%b ready=%b expected busy=0 err=%b valid=0 ready=0000",
                     busy, err_timeout, hn_req_valid, rn_req_ready, m_err);
        end
        to_drive();
        hn_done = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        load_payload();
        m_op[1]  = 7'h01;
        m_txn[1] = 8'h5A;
        rn_req_opcode[OPCODE_W +: OPCODE_W] = m_op[1];
        rn_req_txnid[TXNID_W +: TXNID_W]    = m_txn[1];
        rn_req_valid = 4'b0010;
        hn_req_ready = 1'b1;
        to_neg();
        n_checks++;
        if (rn_req_ready !== 4'b0010) begin
            n_errors++;
            $display("FAIL single_accept: got %b expected 0010", rn_req_ready);
        end
        to_drive();
        to_neg();
        n_checks++;
        if ({obs_offer, rn_req_ready} !== {exp_offer(1), 4'b0000}) begin
            n_errors++;
            $display("FAIL single_offer: got offer=%h ready=%b expected offer=%h ready=0000",
                     obs_offer, rn_req_ready, exp_offer(1));
        end
        to_drive();
        rn_req_valid = '0;
        hn_req_ready = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            hn_done = (j == 5);
            to_neg();
            n_checks++;
            if (busy !== 1'b1) begin
                n_errors++;
                $display("FAIL single_busy%0d: got %b expected 1", j, busy);
            end
            to_drive();
        end
        hn_done = 1'b0;
        to_neg();
        n_checks++;
        if ({busy, err_timeout} !== 2'b00) begin
            n_errors++;
            $display("FAIL single_release: got busy=%b err=%b expected 0 0", busy, err_timeout);
        end
        to_drive();
        m_ptr = 2;
    endtask

    task automatic test_round_robin();
        int grants[$];
        int times[$];
        int expect_order[5] = '{0, 1, 2, 3, 0};
        bit hs_prev;
        int w;
        do_reset();
        load_payload();
        rn_req_valid = 4'hF;
        hn_req_ready = 1'b1;
        hs_prev = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            hn_done = hs_prev;
            to_neg();
            if (rn_req_ready !== 4'b0000) begin
                w = model_winner(4'hF, m_ptr);
                n_checks++;
                if (rn_req_ready !== 4'(1 << w)) begin
                    n_errors++;
                    $display("FAIL rr_ready_cyc%0d: got %b expected %b", cyc, rn_req_ready, 4'(1 << w));
                end
                grants.push_back(w);
                times.push_back(cyc);
                m_ptr = (w + 1) % NUM_RN;
            end
            hs_prev = hn_req_valid && hn_req_ready;
            to_drive();
        end
        n_checks++;
        if (grants.size() < 5) begin
            n_errors++;
            $display("FAIL rr_grant_count: got %0d expected at least 5", grants.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_checks++;
                if (grants[k] != expect_order[k]) begin
                    n_errors++;
                    $display("FAIL rr_order%0d: got %0d expected %0d", k, grants[k], expect_order[k]);
                end
            end
            for (int k = 1; k < times.size(); k++) begin
                n_checks++;
                if (times[k] - times[k-1] != 3) begin
                    n_errors++;
                    $display("FAIL rr_spacing%0d: got %0d expected 3", k, times[k] - times[k-1]);
                end
            end
            for (int k = 3; k < grants.size(); k++) begin
                logic [3:0] seen;
                seen = 4'(1 << grants[k]) | 4'(1 << grants[k-1])
                     | 4'(1 << grants[k-2]) | 4'(1 << grants[k-3]);
                n_checks++;
                if (seen !== 4'hF) begin
                    n_errors++;
                    $display("FAIL rr_fair%0d: got window mask %b expected 1111", k, seen);
                end
            end
        end
        do_reset();
    endtask

    task automatic test_back_pressure();
        do_txn(4'($urandom_range(1, 15)), 20, 3, 1'b1, 1'b1);
    endtask

    task automatic test_done_with_waiter();
        do_reset();
        load_payload();
        rn_req_valid = 4'b0001;
        hn_req_ready = 1'b1;
        to_neg();
        to_drive();
        rn_req_valid = 4'b0100;
        to_neg();
        to_drive();
        hn_req_ready = 1'b0;
        to_neg();
        to_drive();
        hn_done = 1'b1;
        to_neg();
        n_checks++;
        if (rn_req_ready !== 4'b0000) begin
            n_errors++;
            $display("FAIL waiter_in_locked: got %b expected 0000", rn_req_ready);
        end
        to_drive();
        hn_done = 1'b0;
        to_neg();
        n_checks++;
        if (rn_req_ready !== 4'b0100) begin
            n_errors++;
            $display("FAIL waiter_accept: got %b expected 0100", rn_req_ready);
        end
        to_drive();
        rn_req_valid = '0;
        to_neg();
        n_checks++;
        if (obs_offer !== exp_offer(2)) begin
            n_errors++;
            $display("FAIL waiter_offer: got %h expected %h", obs_offer, exp_offer(2));
        end
        to_drive();
        do_reset();
    endtask

    task automatic test_timeout();
        do_reset();
        do_txn(4'($urandom_range(1, 15)), 0, TMO, 1'b1, 1'b0);
        do_txn(4'($urandom_range(1, 15)), 1, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            do_txn(4'($urandom_range(1, 15)), $urandom_range(0, 2), $urandom_range(1, TMO - 1), 1'b1, 1'b0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            do_txn(4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(1, TMO),
                   ($urandom_range(0, 7) != 0), 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        load_payload();
        rn_req_valid = 4'b0001;
        hn_req_ready = 1'b1;
        to_neg();
        to_drive();
        rn_req_valid = '0;
        to_neg();
        to_drive();
        hn_req_ready = 1'b0;
        to_neg();
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_locked_busy: got %b expected 1", busy);
        end
        to_drive();
        rstn = 1'b0;
        to_neg();
        to_drive();
        rstn = 1'b1;
        m_ptr = 0;
        m_err = 1'b0;
        rn_req_valid = 4'b1001;
        to_neg();
        n_checks++;
        if ({obs_offer, busy, err_timeout, rn_req_ready} !== {69'd0, 1'b0, 1'b0, 4'b0001}) begin
            n_errors++;
            $display("FAIL mid_reset: got offer=%h busy=%b err=%b ready=%b expected offer=0 busy=0 err=0 ready=0001",
                     obs_offer, busy, err_timeout, rn_req_ready);
        end
        to_drive();
        rn_req_valid = '0;
        to_neg();
        n_checks++;
        if (obs_offer !== exp_offer(0)) begin
            n_errors++;
            $display("FAIL mid_reset_offer: got %h expected %h", obs_offer, exp_offer(0));
        end
        to_drive();
    endtask

    initial begin
        rstn          = 1'b0;
        rn_req_valid  = '0;
        rn_req_opcode = '0;
        rn_req_addr   = '0;
        rn_req_txnid  = '0;
        hn_req_ready  = 1'b0;
        hn_done       = 1'b0;
        m_ptr         = 0;
        m_err         = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_done_with_waiter();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: simulation did not finish within time limit");
        $fatal(1, "time limit");
    end

endmodule
